td4_program_encoder: RTL and testbench

Encodes a stream of symbolic TD4 instructions (mnemonic + 4-bit immediate) into 8-bit machine words and writes them sequentially into the 16-word program memory. It performs the inverse of the instruction decoder, so the memory is filled with exactly the opcodes the decoder consumes. It sits between a host/loader link (UART or test harness) and the program memory write port, and is active only while the CPU is held.

---
 rtl/td4_pkg.sv | 59 +++++
 rtl/td4_opcode_encode.sv | 39 +++
 rtl/td4_program_encoder.sv | 148 ++++++++++++++
 tb/tb_td4_program_encoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 definitions used by the program encoder, its opcode sub-module
// and anything else that has to agree with the instruction decoder.
//   - mnem_t    : symbolic mnemonic codes accepted from the loader link
//   - OP_*      : 4-bit opcodes exactly as the decoder expects them
//   - ERR_*     : err_code values reported by the encoder
//   - state_t   : encoder FSM state encoding
//   - imm_field : selects the immediate nibble that goes into a word
package td4_pkg;

   typedef enum logic [3:0] {
      MNEM_ADD_A_IM = 4'd0,
      MNEM_MOV_A_B  = 4'd1,
      MNEM_IN_A     = 4'd2,
      MNEM_MOV_A_IM = 4'd3,
      MNEM_MOV_B_A  = 4'd4,
      MNEM_ADD_B_IM = 4'd5,
      MNEM_IN_B     = 4'd6,
      MNEM_MOV_B_IM = 4'd7,
      MNEM_OUT_B    = 4'd8,
      MNEM_OUT_IM   = 4'd9,
      MNEM_JNC_IM   = 4'd10,
      MNEM_JMP_IM   = 4'd11
   } mnem_t;

   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC_IM   = 4'b1110;
   localparam logic [3:0] OP_JMP_IM   = 4'b1111;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_BAD_MNEM = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_PAD  = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // Register-only instructions carry no operand; the decoder ignores the
   // low nibble for them, but we write 0000 so program images are canonical.
   function automatic logic [3:0] imm_field(input mnem_t m, input logic [3:0] imm);
      case (m)
         MNEM_MOV_A_B, MNEM_IN_A, MNEM_MOV_B_A, MNEM_IN_B, MNEM_OUT_B: return 4'h0;
         default: return imm;
      endcase
   endfunction

endpackage

// File: rtl/td4_opcode_encode.sv
// Combinational TD4 instruction encoder: mnemonic + immediate -> 8-bit word.
// Ports:
//   mnem    in  4  mnemonic code (td4_pkg::mnem_t values 0..11 are legal)
//   imm     in  4  immediate operand
//   word    out 8  {opcode, imm field}; 8'h00 when the mnemonic is invalid
//   invalid out 1  mnemonic code 12..15
module td4_opcode_encode
   import td4_pkg::*;
(
   input  logic [3:0] mnem,
   input  logic [3:0] imm,
   output logic [7:0] word,
   output logic       invalid
);

   logic [3:0] opcode;

   always_comb begin
      opcode  = OP_ADD_A_IM;
      invalid = 1'b0;
      case (mnem_t'(mnem))
         MNEM_ADD_A_IM: opcode = OP_ADD_A_IM;
         MNEM_MOV_A_B:  opcode = OP_MOV_A_B;
         MNEM_IN_A:     opcode = OP_IN_A;
         MNEM_MOV_A_IM: opcode = OP_MOV_A_IM;
         MNEM_MOV_B_A:  opcode = OP_MOV_B_A;
         MNEM_ADD_B_IM: opcode = OP_ADD_B_IM;
         MNEM_IN_B:     opcode = OP_IN_B;
         MNEM_MOV_B_IM: opcode = OP_MOV_B_IM;
         MNEM_OUT_B:    opcode = OP_OUT_B;
         MNEM_OUT_IM:   opcode = OP_OUT_IM;
         MNEM_JNC_IM:   opcode = OP_JNC_IM;
         MNEM_JMP_IM:   opcode = OP_JMP_IM;
         default:       invalid = 1'b1;
      endcase
      word = invalid ? 8'h00 : {opcode, imm_field(mnem_t'(mnem), imm)};
   end

endmodule

// File: rtl/td4_program_encoder.sv
// Loads a TD4 program: accepts symbolic instruction beats from a loader link,
// encodes them and writes them sequentially into the 16-word program memory.
// Parameters:
//   PAD_EN   fill the addresses after the last instruction with PAD_WORD
//   PAD_WORD fill word (8'h00 = ADD A,0, a NOP)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin/restart a session at address 0 (wins over beats)
//   in_valid/in_ready   beat handshake; in_ready = LOAD & ~start
//   mnem, imm, last     instruction beat payload
//   mem_we/addr/wdata   program-memory write port (one-cycle strobe)
//   busy, done          status levels (LOAD|PAD, DONE)
//   err_code            00 none, 01 bad mnemonic, 10 overflow
//   count               instruction words written this session (pad excluded)
module td4_program_encoder
   import td4_pkg::*;
#(
   parameter bit         PAD_EN   = 1'b1,
   parameter logic [7:0] PAD_WORD = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] mnem,
   input  logic [3:0] imm,
   input  logic       last,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       busy,
   output logic       done,
   output logic [1:0] err_code,
   output logic [4:0] count
);

   state_t     state_reg;
   logic [3:0] addr_reg;        // next address to be written
   logic [4:0] count_reg;
   logic [1:0] err_reg;
   logic       mem_we_reg;
   logic [3:0] mem_addr_reg;
   logic [7:0] mem_wdata_reg;
   logic       busy_reg;
   logic       done_reg;

   logic [7:0] enc_word;
   logic       enc_invalid;
   logic       beat_accept;

   td4_opcode_encode u_encode (
      .mnem    (mnem),
      .imm     (imm),
      .word    (enc_word),
      .invalid (enc_invalid)
   );

   // The only combinational output: start suppresses acceptance so a
   // restart never consumes a beat belonging to the aborted session.
   assign in_ready    = (state_reg == ST_LOAD) && !start;
   assign beat_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= 4'h0;
         count_reg     <= 5'd0;
         err_reg       <= ERR_NONE;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= 4'h0;
         mem_wdata_reg <= 8'h00;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         mem_we_reg <= 1'b0;
         if (start) begin
            // Restart from any state; words already written stay in memory.
            state_reg <= ST_LOAD;
            addr_reg  <= 4'h0;
            count_reg <= 5'd0;
            err_reg   <= ERR_NONE;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
         end else begin
            case (state_reg)
               ST_LOAD: begin
                  if (beat_accept) begin
                     if (enc_invalid) begin
                        state_reg <= ST_ERR;
                        err_reg   <= ERR_BAD_MNEM;
                        busy_reg  <= 1'b0;
                     end else begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= enc_word;
                        count_reg     <= count_reg + 5'd1;
                        if (addr_reg == 4'hF) begin
                           // Memory full: a missing last flag means the host
                           // sent (or intended) more than 16 instructions.
                           state_reg <= ST_DONE;
                           busy_reg  <= 1'b0;
                           done_reg  <= 1'b1;
                           err_reg   <= last ? ERR_NONE : ERR_OVERFLOW;
                        end else begin
                           addr_reg <= addr_reg + 4'h1;
                           if (last) begin
                              if (PAD_EN) begin
                                 state_reg <= ST_PAD;
                              end else begin
                                 state_reg <= ST_DONE;
                                 busy_reg  <= 1'b0;
                                 done_reg  <= 1'b1;
                              end
                           end
                        end
                     end
                  end
               end
               ST_PAD: begin
                  mem_we_reg    <= 1'b1;
                  mem_addr_reg  <= addr_reg;
                  mem_wdata_reg <= PAD_WORD;
                  if (addr_reg == 4'hF) begin
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     addr_reg <= addr_reg + 4'h1;
                  end
               end
               default: begin
                  // IDLE, DONE and ERR wait for start.
               end
            endcase
         end
      end
   end

   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err_code  = err_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_td4_program_encoder.sv
// Self-checking bench for td4_program_encoder: one padding and one
// non-padding instance share stimulus; sessions are checked against a
// program-level model (write list, count, err_code, done).
module tb_td4_program_encoder;
   import td4_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, last;
   logic [3:0] mnem, imm;

   logic       p_ready, p_we, p_busy, p_done;
   logic [3:0] p_addr;
   logic [7:0] p_wdata;
   logic [1:0] p_err;
   logic [4:0] p_count;

   logic       n_ready, n_we, n_busy, n_done;
   logic [3:0] n_addr;
   logic [7:0] n_wdata;
   logic [1:0] n_err;
   logic [4:0] n_count;

   always #5 clk = ~clk;

   td4_program_encoder #(.PAD_EN(1'b1), .PAD_WORD(8'h00)) dut_pad (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(p_ready),
      .mnem(mnem), .imm(imm), .last(last), .mem_we(p_we), .mem_addr(p_addr),
      .mem_wdata(p_wdata), .busy(p_busy), .done(p_done), .err_code(p_err), .count(p_count)
   );

   td4_program_encoder #(.PAD_EN(1'b0), .PAD_WORD(8'h00)) dut_nopad (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(n_ready),
      .mnem(mnem), .imm(imm), .last(last), .mem_we(n_we), .mem_addr(n_addr),
      .mem_wdata(n_wdata), .busy(n_busy), .done(n_done), .err_code(n_err), .count(n_count)
   );

   // Selected instance view
   bit         use_pad = 1'b1;
   logic       s_ready, s_we, s_busy, s_done;
   logic [3:0] s_addr;
   logic [7:0] s_wdata;
   logic [1:0] s_err;
   logic [4:0] s_count;

   always_comb begin
      s_ready = use_pad ? p_ready : n_ready;
      s_we    = use_pad ? p_we    : n_we;
      s_addr  = use_pad ? p_addr  : n_addr;
      s_wdata = use_pad ? p_wdata : n_wdata;
      s_busy  = use_pad ? p_busy  : n_busy;
      s_done  = use_pad ? p_done  : n_done;
      s_err   = use_pad ? p_err   : n_err;
      s_count = use_pad ? p_count : n_count;
   end

   // Write logs: entry = addr*256 + data
   int p_log[$];
   int n_log[$];
   always @(negedge clk) begin
      if (p_we) p_log.push_back(int'({p_addr, p_wdata}));
      if (n_we) n_log.push_back(int'({n_addr, n_wdata}));
   end

   function automatic int log_size();
      return use_pad ? p_log.size() : n_log.size();
   endfunction

   function automatic int log_at(input int i);
      return use_pad ? p_log[i] : n_log[i];
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0] mnem;
      logic [3:0] imm;
      logic       last;
   } beat_t;

   beat_t prog[$];
   int    exp_w[$];
   int    exp_count, exp_err, exp_done;
   int    sess_idx;
   int    op_tab[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 14, 15};

   // Encoded word for a mnemonic, or -1 if the mnemonic is not defined.
   function automatic int enc_word(input int m, input int i);
      bit no_operand;
      if (m >= 12) return -1;
      no_operand = (m == 1) || (m == 2) || (m == 4) || (m == 6) || (m == 8);
      return op_tab[m] * 16 + (no_operand ? 0 : i);
   endfunction

   function automatic void build_expected(input bit pad);
      int w;
      exp_w.delete();
      exp_count = 0; exp_err = 0; exp_done = 0;
      for (int b = 0; b < prog.size(); b++) begin
         w = enc_word(int'(prog[b].mnem), int'(prog[b].imm));
         if (w < 0) begin
            exp_err = 1;
            break;
         end
         exp_w.push_back(b * 256 + w);
         exp_count++;
         if (prog[b].last || b == 15) begin
            exp_done = 1;
            if (!prog[b].last) exp_err = 2;
            else if (pad) for (int j = b + 1; j < 16; j++) exp_w.push_back(j * 256);
            break;
         end
      end
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1; in_valid = 1'b0; last = 1'b0;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (s_busy && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("finish_busy", s_busy, 0);
   endtask

   // Run the program in prog on the selected instance and check everything.
   task automatic run_prog(input bit pad, input bit gaps);
      int t, w;
      use_pad = pad;
      build_expected(pad);
      pulse_start();
      sess_idx = log_size();
      check("start_busy", s_busy, 1);
      check("start_count", s_count, 0);
      check("start_err", s_err, 0);
      for (int b = 0; b < prog.size(); b++) begin
         if (gaps && $urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1; mnem = prog[b].mnem; imm = prog[b].imm; last = prog[b].last;
         #1;
         t = 0;
         while (!s_ready && t < 4) begin
            @(negedge clk); #1; t++;
         end
         check("beat_ready", s_ready, 1);
         if (!s_ready) break;
         @(posedge clk);
         @(negedge clk);
         w = enc_word(int'(prog[b].mnem), int'(prog[b].imm));
         if (w < 0) begin
            check("bad_no_we", s_we, 0);
            check("bad_err", s_err, ERR_BAD_MNEM);
            break;
         end
         check("beat_we", s_we, 1);
         check("beat_addr", s_addr, b);
         check("beat_data", s_wdata, w);
         if (prog[b].last || b == 15) break;
      end
      in_valid = 1'b0; last = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check("end_done", s_done, exp_done);
      check("end_err", s_err, exp_err);
      check("end_count", s_count, exp_count);
      check("end_ready", s_ready, 0);
      check("n_writes", log_size() - sess_idx, exp_w.size());
      for (int i = 0; i < exp_w.size() && sess_idx + i < log_size(); i++)
         check("wr_entry", log_at(sess_idx + i), exp_w[i]);
      $display("session pad=%0d beats=%0d writes=%0d count=%0d err=%0d done=%0d",
               pad, prog.size(), log_size() - sess_idx, s_count, s_err, s_done);
   endtask

   function automatic void add_beat(input logic [3:0] m, input logic [3:0] i, input logic l);
      beat_t bt;
      bt.mnem = m; bt.imm = i; bt.last = l;
      prog.push_back(bt);
   endfunction

   // Single-beat encoding table: {mnem, imm, expected word, expected err}
   typedef struct {
      logic [3:0] mnem;
      logic [3:0] imm;
      logic [7:0] exp_word;
      logic [1:0] exp_err;
   } vec_t;

   vec_t vtab[16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sidx, len, m;
      logic l;

      vtab[0]  = '{4'd0,  4'h5, 8'h05, 2'd0};
      vtab[1]  = '{4'd1,  4'h7, 8'h10, 2'd0};
      vtab[2]  = '{4'd2,  4'h9, 8'h20, 2'd0};
      vtab[3]  = '{4'd3,  4'hA, 8'h3A, 2'd0};
      vtab[4]  = '{4'd4,  4'h3, 8'h40, 2'd0};
      vtab[5]  = '{4'd5,  4'hC, 8'h5C, 2'd0};
      vtab[6]  = '{4'd6,  4'hF, 8'h60, 2'd0};
      vtab[7]  = '{4'd7,  4'h1, 8'h71, 2'd0};
      vtab[8]  = '{4'd8,  4'h6, 8'h90, 2'd0};
      vtab[9]  = '{4'd9,  4'hD, 8'hBD, 2'd0};
      vtab[10] = '{4'd10, 4'h2, 8'hE2, 2'd0};
      vtab[11] = '{4'd11, 4'hE, 8'hFE, 2'd0};
      vtab[12] = '{4'd12, 4'h0, 8'h00, 2'd1};
      vtab[13] = '{4'd13, 4'h4, 8'h00, 2'd1};
      vtab[14] = '{4'd14, 4'h8, 8'h00, 2'd1};
      vtab[15] = '{4'd15, 4'hF, 8'h00, 2'd1};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; mnem = 4'h0; imm = 4'h0; last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", p_ready, 0);
      check("rst_we", p_we, 0);
      check("rst_addr", p_addr, 0);
      check("rst_wdata", p_wdata, 0);
      check("rst_busy", p_busy, 0);
      check("rst_done", p_done, 0);
      check("rst_err", p_err, 0);
      check("rst_count", p_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", p_ready, 0);

      // Example program with padding
      prog.delete();
      add_beat(MNEM_MOV_A_IM, 4'd3, 1'b0);
      add_beat(MNEM_ADD_A_IM, 4'd1, 1'b0);
      add_beat(MNEM_JMP_IM, 4'd1, 1'b1);
      run_prog(1'b1, 1'b0);
      check("ex_nwr", log_size() - sess_idx, 16);
      check("ex_w0", log_at(sess_idx), 'h033);
      check("ex_w1", log_at(sess_idx + 1), 'h101);
      check("ex_w2", log_at(sess_idx + 2), 'h2F1);
      check("ex_w15", log_at(sess_idx + 15), 'hF00);
      check("ex_count", s_count, 3);

      // Register-only form, no padding
      prog.delete();
      add_beat(MNEM_MOV_A_B, 4'd7, 1'b1);
      run_prog(1'b0, 1'b0);
      check("nopad_nwr", log_size() - sess_idx, 1);
      check("nopad_w0", log_at(sess_idx), 'h010);

      // 16 beats without last -> overflow
      prog.delete();
      for (int i = 0; i < 16; i++) add_beat(MNEM_OUT_IM, 4'(i), 1'b0);
      run_prog(1'b1, 1'b0);
      check("ovf_err", s_err, 2);
      check("ovf_count", s_count, 16);
      check("ovf_w15", log_at(sess_idx + 15), 'hFBF);

      // Bad mnemonic on beat 2, then ERR holds off further beats
      prog.delete();
      add_beat(MNEM_ADD_B_IM, 4'd2, 1'b0);
      add_beat(4'd12, 4'd0, 1'b0);
      run_prog(1'b1, 1'b0);
      check("bad_nwr", log_size() - sess_idx, 1);
      in_valid = 1'b1; mnem = 4'd0; imm = 4'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("err_ready_low", s_ready, 0);
         check("err_no_we", s_we, 0);
      end
      in_valid = 1'b0;

      // Table of single-beat encodings
      for (int v = 0; v < 16; v++) begin
         prog.delete();
         add_beat(vtab[v].mnem, vtab[v].imm, 1'b1);
         run_prog(1'b0, 1'b0);
         check("tab_err", s_err, vtab[v].exp_err);
         if (vtab[v].exp_err == 2'd0) check("tab_word", log_at(sess_idx), int'(vtab[v].exp_word));
         else check("tab_nwr", log_size() - sess_idx, 0);
      end

      // start collides with beat 5: beat dropped, session restarts at 0
      use_pad = 1'b1;
      pulse_start();
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1; mnem = MNEM_ADD_B_IM; imm = 4'(b); last = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      check("abort_pre_addr", s_addr, 3);
      check("abort_pre_count", s_count, 4);
      start = 1'b1; mnem = MNEM_MOV_B_IM; imm = 4'd9;
      #1;
      check("abort_ready", s_ready, 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("abort_we", s_we, 0);
      check("abort_count", s_count, 0);
      check("abort_busy", s_busy, 1);
      last = 1'b1;
      #1;
      check("abort_ready2", s_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; last = 1'b0;
      check("abort_we2", s_we, 1);
      check("abort_addr", s_addr, 0);
      check("abort_data", s_wdata, 'h79);
      check("abort_count2", s_count, 1);
      wait_idle();
      $display("session abort-restart count=%0d done=%0d", s_count, s_done);

      // rst during the third PAD cycle
      use_pad = 1'b1;
      pulse_start();
      in_valid = 1'b1; mnem = MNEM_ADD_A_IM; imm = 4'd2; last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; last = 1'b0;
      check("pad_w0_we", s_we, 1);
      check("pad_w0_data", s_wdata, 'h02);
      @(negedge clk);
      check("pad_busy", s_busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("prst_we", s_we, 0);
      check("prst_addr", s_addr, 0);
      check("prst_wdata", s_wdata, 0);
      check("prst_busy", s_busy, 0);
      check("prst_done", s_done, 0);
      check("prst_err", s_err, 0);
      check("prst_count", s_count, 0);
      check("prst_ready", s_ready, 0);
      rst = 1'b0;
      sidx = log_size();
      repeat (6) @(negedge clk);
      check("prst_no_writes", log_size() - sidx, 0);
      $display("session rst-in-pad writes_after_rst=%0d", log_size() - sidx);

      // Randomized programs
      for (int r = 0; r < 40; r++) begin
         prog.delete();
         len = $urandom_range(16, 1);
         for (int b = 0; b < len; b++) begin
            m = ($urandom_range(19) == 0) ? $urandom_range(15, 12) : $urandom_range(11, 0);
            if (b == len - 1) l = (len == 16) ? 1'($urandom_range(1)) : 1'b1;
            else l = 1'b0;
            add_beat(4'(m), 4'($urandom_range(15)), l);
         end
         run_prog(1'($urandom_range(1)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
